slave_mem_arbiter: RTL and testbench

Round-robin arbiter sharing the SoC's single-ported slave memory between three masters: instruction fetch (port 0), data load/store (port 1) and the program loader/debug port (port 2). It sits between the core's bus masters and the slave memory wrapper. It grants one transaction at a time, tracks the outstanding access through the memory's fixed read latency, and routes the response back to the owning master. Out-of-range addresses are rejected with an error response and never reach the memory.

---
 rtl/slave_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_slave_mem_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slave_mem_arbiter.sv
// Purpose : round-robin sharing of one single-ported slave memory between
//           fetch (0), load/store (1) and loader/debug (2) masters.
// Latency : grant is combinational; response exactly MEM_LAT cycles after grant.
// Backpr. : one outstanding access; masters hold m_req and fields until m_gnt.
//
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   m_req/m_we/...    - per-master request buses, master i at slice i
//   m_gnt             - one-hot single-cycle grant
//   m_rvalid/m_err    - one-hot response strobe and out-of-range flag
//   m_rdata           - shared read data (0 for writes and errors)
//   mem_*             - memory command (all zero when mem_en is low)
//   busy              - a transaction is outstanding
module slave_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 4096,
    parameter int MEM_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2:0]              m_req,
    input  logic [2:0]              m_we,
    input  logic [3*ADDR_W-1:0]     m_addr,
    input  logic [3*DATA_W-1:0]     m_wdata,
    input  logic [3*DATA_W/8-1:0]   m_wstrb,
    output logic [2:0]              m_gnt,
    output logic [2:0]              m_rvalid,
    output logic [2:0]              m_err,
    output logic [DATA_W-1:0]       m_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [DATA_W/8-1:0]     mem_wstrb,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    busy
);

    localparam int         STRB_W   = DATA_W / 8;
    localparam logic [1:0] CNT_LOAD = 2'(MEM_LAT - 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t              state, state_nxt;
    logic [1:0]          cnt;
    logic [1:0]          last;
    logic [1:0]          owner;
    logic                err_q;
    logic                rd_q;      // response carries memory data

    logic [1:0]          start;
    logic [2:0]          rr_sum;
    logic                win_vld;
    logic [1:0]          win_idx;
    logic                resp;
    logic                can_grant;
    logic                grant;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_in_range;

    // Search begins one past the last winner.
    assign start = (last == 2'd2) ? 2'd0 : last + 2'd1;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        rr_sum  = 3'd0;
        for (int k = 0; k < 3; k++) begin
            rr_sum = {1'b0, start} + 3'(k);
            if (rr_sum >= 3'd3) rr_sum = rr_sum - 3'd3;
            if (!win_vld && m_req[rr_sum[1:0]]) begin
                win_vld = 1'b1;
                win_idx = rr_sum[1:0];
            end
        end
    end

    assign resp = (state == S_WAIT) && (cnt == 2'd0);

    // Grant is combinational from m_req, so it is also masked while reset is
    // asserted to keep every output at zero during reset.
    assign can_grant    = reset && ((state == S_IDLE) || resp);
    assign grant        = can_grant && win_vld;
    assign sel_addr     = m_addr[win_idx*ADDR_W +: ADDR_W];
    assign sel_in_range = sel_addr < ADDR_W'(MEM_BYTES);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: a grant on the response cycle keeps the FSM in WAIT.
    always_comb begin
        state_nxt = state;
        if (grant)     state_nxt = S_WAIT;
        else if (resp) state_nxt = S_IDLE;
    end

    // Transaction bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 2'd0;
            last  <= 2'd2;
            owner <= 2'd0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else if (grant) begin
            cnt   <= CNT_LOAD;
            last  <= win_idx;
            owner <= win_idx;
            err_q <= !sel_in_range;
            rd_q  <= sel_in_range && !m_we[win_idx];
        end else if ((state == S_WAIT) && (cnt != 2'd0)) begin
            cnt   <= cnt - 2'd1;
        end
    end

    // Outputs
    always_comb begin
        m_gnt     = 3'b000;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (grant) begin
            m_gnt[win_idx] = 1'b1;
            if (sel_in_range) begin
                mem_en    = 1'b1;
                mem_we    = m_we[win_idx];
                mem_addr  = sel_addr;
                mem_wdata = m_wdata[win_idx*DATA_W +: DATA_W];
                mem_wstrb = m_wstrb[win_idx*STRB_W +: STRB_W];
            end
        end

        m_rvalid = 3'b000;
        m_err    = 3'b000;
        m_rdata  = '0;
        if (resp) begin
            m_rvalid[owner] = 1'b1;
            m_err[owner]    = err_q;
            if (rd_q) m_rdata = mem_rdata;
        end
    end

    assign busy = (state == S_WAIT);

endmodule

// File: tb/tb_slave_mem_arbiter.sv
// Bench for slave_mem_arbiter: instance A runs MEM_LAT=1, instance B MEM_LAT=3.
// Each instance has a small behavioural memory with the matching read latency;
// expected responses are queued when requests are driven and checked on m_rvalid.
module tb_slave_mem_arbiter;

    typedef logic [37:0] rsp_t;   // {m_rvalid, m_err, m_rdata}

    logic clk;
    int   total = 0;
    int   bad   = 0;

    // ---------------- instance A (MEM_LAT = 1) ----------------
    logic        a_reset;
    logic [2:0]  a_req, a_we;
    logic [95:0] a_addr, a_wdata;
    logic [11:0] a_wstrb;
    logic [2:0]  a_gnt, a_rvalid, a_err;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [3:0]  a_mem_wstrb;

    // ---------------- instance B (MEM_LAT = 3) ----------------
    logic        b_reset;
    logic [2:0]  b_req, b_we;
    logic [95:0] b_addr, b_wdata;
    logic [11:0] b_wstrb;
    logic [2:0]  b_gnt, b_rvalid, b_err;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [3:0]  b_mem_wstrb;

    rsp_t a_q[$];
    rsp_t b_q[$];

    slave_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(a_reset),
        .m_req(a_req), .m_we(a_we), .m_addr(a_addr), .m_wdata(a_wdata), .m_wstrb(a_wstrb),
        .m_gnt(a_gnt), .m_rvalid(a_rvalid), .m_err(a_err), .m_rdata(a_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rdata(a_mem_rdata),
        .busy(a_busy)
    );

    slave_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(4096), .MEM_LAT(3)) u_b (
        .clk(clk), .reset(b_reset),
        .m_req(b_req), .m_we(b_we), .m_addr(b_addr), .m_wdata(b_wdata), .m_wstrb(b_wstrb),
        .m_gnt(b_gnt), .m_rvalid(b_rvalid), .m_err(b_err), .m_rdata(b_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rdata(b_mem_rdata),
        .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural memories ----------------
    // Non-read cycles present junk on the read bus so masking is observable.
    logic        a_bd_en, b_bd_en;
    logic [7:0]  a_bd_idx, b_bd_idx;
    logic [31:0] a_bd_dat, b_bd_dat;
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    logic [31:0] a_p1, b_p1, b_p2, b_p3;

    always @(posedge clk) begin
        if (a_bd_en) a_mem[a_bd_idx] <= a_bd_dat;
        if (a_mem_en && a_mem_we)
            for (int i = 0; i < 4; i++)
                if (a_mem_wstrb[i]) a_mem[a_mem_addr[9:2]][8*i +: 8] <= a_mem_wdata[8*i +: 8];
        a_p1 <= (a_mem_en && !a_mem_we) ? a_mem[a_mem_addr[9:2]] : 32'hBADBAD00;
    end
    assign a_mem_rdata = a_p1;

    always @(posedge clk) begin
        if (b_bd_en) b_mem[b_bd_idx] <= b_bd_dat;
        if (b_mem_en && b_mem_we)
            for (int i = 0; i < 4; i++)
                if (b_mem_wstrb[i]) b_mem[b_mem_addr[9:2]][8*i +: 8] <= b_mem_wdata[8*i +: 8];
        b_p1 <= (b_mem_en && !b_mem_we) ? b_mem[b_mem_addr[9:2]] : 32'hBADBAD00;
        b_p2 <= b_p1;
        b_p3 <= b_p2;
    end
    assign b_mem_rdata = b_p3;

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit sel_b, input logic [7:0] idx, input logic [31:0] dat);
        if (sel_b) begin b_bd_en = 1'b1; b_bd_idx = idx; b_bd_dat = dat; end
        else       begin a_bd_en = 1'b1; a_bd_idx = idx; a_bd_dat = dat; end
        cyc();
        a_bd_en = 1'b0;
        b_bd_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        a_req = 3'b111;
        b_req = 3'b111;
        @(negedge clk);
        total++;
        if ({a_gnt, a_rvalid, a_err, a_rdata, a_mem_en, a_mem_we, a_mem_addr,
             a_mem_wdata, a_mem_wstrb, a_busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_a: gnt=%b rvalid=%b mem_en=%b busy=%b, required all 0",
                     a_gnt, a_rvalid, a_mem_en, a_busy);
        end
        total++;
        if ({b_gnt, b_rvalid, b_err, b_rdata, b_mem_en, b_mem_we, b_mem_addr,
             b_mem_wdata, b_mem_wstrb, b_busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_b: gnt=%b rvalid=%b mem_en=%b busy=%b, required all 0",
                     b_gnt, b_rvalid, b_mem_en, b_busy);
        end
        a_req = 3'b000;
        b_req = 3'b000;
        cyc();
        a_reset = 1'b1;
        b_reset = 1'b1;
        @(negedge clk);
        total++;
        if ({a_busy, b_busy, a_gnt, b_gnt} !== 8'h00) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b/%b gnt=%b/%b, required 0",
                     a_busy, b_busy, a_gnt, b_gnt);
        end
        cyc();
    endtask

    task automatic test_single_read();
        rsp_t e;
        preload(1'b0, 8'd4, 32'hDEADBEEF);
        a_we           = 3'b000;
        a_addr[31:0]   = 32'h10;
        a_req          = 3'b001;
        a_q.push_back({3'b001, 3'b000, 32'hDEADBEEF});
        @(negedge clk);
        total++;
        if ({a_gnt, a_mem_en, a_mem_we, a_mem_addr} !== {3'b001, 1'b1, 1'b0, 32'h10}) begin
            bad++;
            $display("FAIL single_read_grant: gnt=%b en=%b we=%b addr=%h, required 001 1 0 00000010",
                     a_gnt, a_mem_en, a_mem_we, a_mem_addr);
        end
        cyc();
        a_req = 3'b000;
        @(negedge clk);
        total++;
        e = '1;
        if (a_q.size() != 0) e = a_q.pop_front();
        if ({a_rvalid, a_err, a_rdata} !== e) begin
            bad++;
            $display("FAIL single_read_rsp: got=%h required=%h", {a_rvalid, a_err, a_rdata}, e);
        end
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_read_busy: busy=%b required 1", a_busy);
        end
        cyc();
    endtask

    task automatic test_out_of_range();
        rsp_t e;
        a_we            = 3'b100;
        a_addr[64 +: 32] = 32'h2000;
        a_wdata[64 +: 32] = 32'h12345678;
        a_wstrb[8 +: 4] = 4'hF;
        a_req           = 3'b100;
        a_q.push_back({3'b100, 3'b100, 32'h0});
        @(negedge clk);
        total++;
        if ({a_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wstrb} !==
            {3'b100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
            bad++;
            $display("FAIL oor_grant: gnt=%b en=%b addr=%h wdata=%h, required 100 0 0 0",
                     a_gnt, a_mem_en, a_mem_addr, a_mem_wdata);
        end
        cyc();
        a_req = 3'b000;
        a_we  = 3'b000;
        @(negedge clk);
        total++;
        e = '1;
        if (a_q.size() != 0) e = a_q.pop_front();
        if ({a_rvalid, a_err, a_rdata} !== e) begin
            bad++;
            $display("FAIL oor_rsp: got=%h required=%h", {a_rvalid, a_err, a_rdata}, e);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        rsp_t        e;
        logic [2:0]  exp_gnt;
        logic [31:0] vals [3];
        for (int i = 0; i < 3; i++) begin
            vals[i] = 32'hC0DE0000 | 32'(i);
            preload(1'b0, 8'(64 + i), vals[i]);
            a_addr[i*32 +: 32] = 32'h100 + 32'(4 * i);
        end
        a_we  = 3'b000;
        a_req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_gnt = 3'(3'b001 << (k % 3));
            a_q.push_back({exp_gnt, 3'b000, vals[k % 3]});
            @(negedge clk);
            total++;
            if (a_gnt !== exp_gnt) begin
                bad++;
                $display("FAIL rr_grant[%0d]: gnt=%b required=%b", k, a_gnt, exp_gnt);
            end
            if (k > 0) begin
                total++;
                e = '1;
                if (a_q.size() != 0) e = a_q.pop_front();
                if ({a_rvalid, a_err, a_rdata} !== e) begin
                    bad++;
                    $display("FAIL rr_rsp[%0d]: got=%h required=%h", k - 1,
                             {a_rvalid, a_err, a_rdata}, e);
                end
            end
            cyc();
            if (k == 5) a_req = 3'b000;
        end
        @(negedge clk);
        total++;
        e = '1;
        if (a_q.size() != 0) e = a_q.pop_front();
        if ({a_rvalid, a_err, a_rdata} !== e) begin
            bad++;
            $display("FAIL rr_rsp[5]: got=%h required=%h", {a_rvalid, a_err, a_rdata}, e);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        a_we             = 3'b010;
        a_addr[32 +: 32] = 32'h20;
        a_wdata[32 +: 32] = 32'hA5A5A5A5;
        a_wstrb[4 +: 4]  = 4'hF;
        a_req            = 3'b010;
        a_q.push_back({3'b010, 3'b000, 32'h0});
        @(negedge clk);
        total++;
        if ({a_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wstrb} !==
            {3'b010, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF}) begin
            bad++;
            $display("FAIL wr_grant: gnt=%b en=%b we=%b addr=%h wdata=%h strb=%h",
                     a_gnt, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wstrb);
        end
        cyc();
        a_we          = 3'b000;
        a_addr[31:0]  = 32'h20;
        a_req         = 3'b001;
        a_q.push_back({3'b001, 3'b000, 32'hA5A5A5A5});
        @(negedge clk);
        total++;
        if (a_gnt !== 3'b001) begin
            bad++;
            $display("FAIL rd_grant_overlap: gnt=%b required=001", a_gnt);
        end
        total++;
        e = '1;
        if (a_q.size() != 0) e = a_q.pop_front();
        if ({a_rvalid, a_err, a_rdata} !== e) begin
            bad++;
            $display("FAIL wr_rsp: got=%h required=%h", {a_rvalid, a_err, a_rdata}, e);
        end
        cyc();
        a_req = 3'b000;
        @(negedge clk);
        total++;
        e = '1;
        if (a_q.size() != 0) e = a_q.pop_front();
        if ({a_rvalid, a_err, a_rdata} !== e) begin
            bad++;
            $display("FAIL rd_after_wr: got=%h required=%h", {a_rvalid, a_err, a_rdata}, e);
        end
        cyc();
    endtask

    task automatic test_latency3();
        rsp_t       e;
        logic [2:0] exp_gnt;
        preload(1'b1, 8'd16, 32'h11111111);
        preload(1'b1, 8'd17, 32'h22222222);
        b_we             = 3'b000;
        b_addr[32 +: 32] = 32'h40;
        b_addr[64 +: 32] = 32'h44;
        b_req            = 3'b110;
        b_q.push_back({3'b010, 3'b000, 32'h11111111});
        b_q.push_back({3'b100, 3'b000, 32'h22222222});
        for (int c = 0; c <= 6; c++) begin
            exp_gnt = (c == 0) ? 3'b010 : (c == 3) ? 3'b100 : 3'b000;
            @(negedge clk);
            total++;
            if (b_gnt !== exp_gnt) begin
                bad++;
                $display("FAIL lat3_grant[t+%0d]: gnt=%b required=%b", c, b_gnt, exp_gnt);
            end
            total++;
            if (c == 3 || c == 6) begin
                e = '1;
                if (b_q.size() != 0) e = b_q.pop_front();
                if ({b_rvalid, b_err, b_rdata} !== e) begin
                    bad++;
                    $display("FAIL lat3_rsp[t+%0d]: got=%h required=%h", c,
                             {b_rvalid, b_err, b_rdata}, e);
                end
            end else if (b_rvalid !== 3'b000) begin
                bad++;
                $display("FAIL lat3_quiet[t+%0d]: rvalid=%b required=000", c, b_rvalid);
            end
            cyc();
            if (c == 0) b_req = 3'b100;
            if (c == 3) b_req = 3'b000;
        end
    endtask

    task automatic test_reset_mid();
        rsp_t e;
        b_we         = 3'b000;
        b_addr[31:0] = 32'h40;
        b_req        = 3'b001;
        @(negedge clk);
        total++;
        if (b_gnt !== 3'b001) begin
            bad++;
            $display("FAIL mid_pre_grant: gnt=%b required=001", b_gnt);
        end
        cyc();
        b_req   = 3'b111;
        b_reset = 1'b0;
        #1;
        total++;
        if ({b_gnt, b_rvalid, b_err, b_rdata, b_mem_en, b_mem_we, b_mem_addr,
             b_mem_wdata, b_mem_wstrb, b_busy} !== '0) begin
            bad++;
            $display("FAIL mid_reset_async: gnt=%b rvalid=%b en=%b busy=%b, required all 0",
                     b_gnt, b_rvalid, b_mem_en, b_busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({b_rvalid, b_gnt, b_busy} !== 7'd0) begin
                bad++;
                $display("FAIL mid_reset_hold[%0d]: rvalid=%b gnt=%b busy=%b, required 0",
                         c, b_rvalid, b_gnt, b_busy);
            end
            cyc();
        end
        b_reset = 1'b1;
        b_q.push_back({3'b001, 3'b000, 32'h11111111});
        @(negedge clk);
        total++;
        if (b_gnt !== 3'b001) begin
            bad++;
            $display("FAIL post_reset_grant: gnt=%b required=001", b_gnt);
        end
        cyc();
        b_req = 3'b000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (c == 3) begin
                e = '1;
                if (b_q.size() != 0) e = b_q.pop_front();
                if ({b_rvalid, b_err, b_rdata} !== e) begin
                    bad++;
                    $display("FAIL post_reset_rsp: got=%h required=%h",
                             {b_rvalid, b_err, b_rdata}, e);
                end
            end else if (b_rvalid !== 3'b000) begin
                bad++;
                $display("FAIL post_reset_quiet[%0d]: rvalid=%b required=000", c, b_rvalid);
            end
            cyc();
        end
        total++;
        if (a_q.size() != 0 || b_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending a=%0d b=%0d required 0",
                     a_q.size(), b_q.size());
        end
    endtask

    initial begin
        a_reset = 1'b0;  b_reset = 1'b0;
        a_req   = '0;    b_req   = '0;
        a_we    = '0;    b_we    = '0;
        a_addr  = '0;    b_addr  = '0;
        a_wdata = '0;    b_wdata = '0;
        a_wstrb = '0;    b_wstrb = '0;
        a_bd_en = 1'b0;  b_bd_en = 1'b0;
        a_bd_idx = '0;   b_bd_idx = '0;
        a_bd_dat = '0;   b_bd_dat = '0;

        test_reset();
        test_single_read();
        test_out_of_range();
        test_round_robin();
        test_back_to_back();
        test_latency3();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
